colparity_ctrl: RTL

Sequencer for the column-parity (theta) step of the encoder's 5x5 lane state. On `start` it clears the parity accumulators, streams all 25 lanes from state memory into the column-parity datapath, then streams them again while writing back each lane with its theta correction. It sits between the top-level encoder FSM and the state RAM / column-parity datapath, and owns the lane and column counters those units need.

---
 rtl/colparity_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/colparity_ctrl.sv
// rtl/colparity_ctrl.sv - theta-step sequencer: clear, accumulate 25 lanes, write back with column indices
module colparity_ctrl #(
  parameter int LANES  = 25,
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          par_clr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          acc_en,
  output logic [2:0]    acc_x,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [2:0]    th_xm1,
  output logic [2:0]    th_xp1
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_DRAIN, S_UPDATE, S_FLUSH, S_DONE
  } state_t;

  localparam int T = RD_LAT - 1;

  state_t        state_q;
  logic [2:0]    x_q, y_q, x_d, y_d;
  logic [AW-1:0] lane_q, lane_d;
  logic [1:0]    dly_q;
  logic          busy_q, done_q, par_clr_q;
  logic          issuing, last_lane, phase, streaming;

  logic [RD_LAT-1:0] pv_q, pp_q;
  logic [AW-1:0]     pl_q [RD_LAT];
  logic [2:0]        px_q [RD_LAT];

  assign streaming = (state_q == S_READ) || (state_q == S_UPDATE);
  assign issuing   = streaming && !hold;
  assign last_lane = (lane_q == AW'(LANES - 1));
  assign phase     = (state_q == S_UPDATE);

  // x wraps 4->0 and carries into y; the lane counter tracks 5*y+x directly
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    lane_d = last_lane ? '0 : lane_q + AW'(1);
    if (x_q == 3'd4) begin
      x_d = 3'd0;
      y_d = (y_q == 3'd4) ? 3'd0 : y_q + 3'd1;
    end else begin
      x_d = x_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      lane_q    <= '0;
      dly_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_clr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q   <= S_CLR;
          busy_q    <= 1'b1;
          par_clr_q <= 1'b1;
        end
        S_CLR: begin
          par_clr_q <= 1'b0;
          x_q       <= '0;
          y_q       <= '0;
          lane_q    <= '0;
          state_q   <= S_READ;
        end
        S_READ, S_UPDATE: if (!hold) begin
          x_q    <= x_d;
          y_q    <= y_d;
          lane_q <= lane_d;
          if (last_lane) begin
            dly_q   <= '0;
            state_q <= (state_q == S_READ) ? S_DRAIN : S_FLUSH;
          end
        end
        S_DRAIN: begin
          if (dly_q == 2'(RD_LAT - 1)) begin
            x_q     <= '0;
            y_q     <= '0;
            lane_q  <= '0;
            state_q <= S_UPDATE;
          end else begin
            dly_q <= dly_q + 2'd1;
          end
        end
        S_FLUSH: begin
          if (dly_q == 2'(RD_LAT - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            dly_q <= dly_q + 2'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Return path: keeps shifting during hold so in-flight reads still retire
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv_q <= '0;
      pp_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pl_q[i] <= '0;
        px_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= issuing;
      pp_q[0] <= phase;
      pl_q[0] <= lane_q;
      px_q[0] <= x_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pl_q[i] <= pl_q[i-1];
        px_q[i] <= px_q[i-1];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign par_clr = par_clr_q;
  assign rd_en   = issuing;
  assign rd_addr = streaming ? lane_q : '0;
  assign acc_en  = pv_q[T] & ~pp_q[T];
  assign wr_en   = pv_q[T] & pp_q[T];
  assign acc_x   = acc_en ? px_q[T] : '0;
  assign wr_addr = wr_en ? pl_q[T] : '0;
  assign th_xm1  = !wr_en ? 3'd0 : ((px_q[T] == 3'd0) ? 3'd4 : px_q[T] - 3'd1);
  assign th_xp1  = !wr_en ? 3'd0 : ((px_q[T] == 3'd4) ? 3'd0 : px_q[T] + 3'd1);

endmodule
